// File: rtl/axi_cache_pkg.sv
// Shared AXI write-path encodings and the burst controller state type.
// Used by axi_wr_burst_ctrl and axi_addr_gen.
package axi_cache_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RESP  = 2'd2
  } wr_state_e;

  // WRAP bursts must span 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; purely combinational, no
// latency, no flow control.
module axi_addr_gen
  import axi_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_burst,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;

  assign w_step      = ADDR_WIDTH'(1) << i_size;
  assign w_incr      = i_addr + w_step;
  // Wrap window is (len+1) beats of 2^size bytes; legal lengths make it a power of two.
  assign w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);

  always_comb begin
    o_next_addr = i_addr;
    case (burst_e'(i_burst))
      BURST_INCR: o_next_addr = w_incr;
      BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:    o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// Splits one AXI write burst into per-beat cache write requests and returns B.
// W->cache is combinational (zero latency); wready follows cache ready; one burst outstanding.
module axi_wr_burst_ctrl
  import axi_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   in_awaddr,
  input  logic [ID_WIDTH-1:0]     in_awid,
  input  logic [1:0]              in_awburst,
  input  logic [2:0]              in_awsize,
  input  logic [7:0]              in_awlen,
  input  logic                    in_awvalid,
  output logic                    in_awready,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [DATA_WIDTH/8-1:0] in_wstrb,
  input  logic                    in_wlast,
  input  logic                    in_wvalid,
  output logic                    in_wready,
  output logic [ID_WIDTH-1:0]     out_bid,
  output logic [1:0]              out_bresp,
  output logic                    out_bvalid,
  input  logic                    out_bready,
  output logic [ADDR_WIDTH-1:0]   wr_req_addr,
  output logic [DATA_WIDTH-1:0]   wr_req_data,
  output logic [DATA_WIDTH/8-1:0] wr_req_strb,
  output logic                    wr_req_valid,
  input  logic                    wr_req_ready
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));

  wr_state_e             r_state;
  wr_state_e             w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_burst;
  logic [2:0]            r_size;
  logic [7:0]            r_len;
  logic [8:0]            r_cnt;
  logic                  r_drop;
  logic                  r_err;

  logic                  w_aw_hs;
  logic                  w_aw_bad;
  logic                  w_beat;
  logic                  w_cnt_term;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  axi_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_burst     (r_burst),
    .i_size      (r_size),
    .i_len       (r_len),
    .o_next_addr (w_next_addr)
  );

  assign w_aw_hs    = in_awvalid && in_awready;
  assign w_aw_bad   = (in_awburst == BURST_RSVD) || (in_awsize > SIZE_MAX) ||
                      ((in_awburst == BURST_WRAP) && !wrap_len_ok(in_awlen));
  assign w_beat     = (r_state == ST_BURST) && in_wvalid && in_wready;
  assign w_cnt_term = (r_cnt == {1'b0, r_len});

  assign wr_req_addr = r_addr;
  assign wr_req_data = in_wdata;
  assign wr_req_strb = in_wstrb;

  always_comb begin
    w_state_nxt  = r_state;
    in_awready   = 1'b0;
    in_wready    = 1'b0;
    wr_req_valid = 1'b0;
    out_bvalid   = 1'b0;
    out_bid      = '0;
    out_bresp    = RESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        in_awready = 1'b1;
        if (w_aw_hs) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        // Illegal bursts are swallowed: every beat accepted, nothing forwarded.
        if (r_drop) begin
          in_wready = 1'b1;
        end else begin
          in_wready    = wr_req_ready;
          wr_req_valid = in_wvalid;
        end
        if (w_beat && w_cnt_term) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        out_bvalid = 1'b1;
        out_bid    = r_id;
        out_bresp  = (r_drop || r_err) ? RESP_SLVERR : RESP_OKAY;
        if (out_bready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_burst <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_hs) begin
        r_id    <= in_awid;
        r_addr  <= in_awaddr;
        r_burst <= in_awburst;
        r_size  <= in_awsize;
        r_len   <= in_awlen;
        r_cnt   <= '0;
        r_drop  <= w_aw_bad;
        r_err   <= 1'b0;
      end else if (w_beat) begin
        r_cnt  <= r_cnt + 9'd1;
        r_addr <= w_next_addr;
        if (in_wlast != w_cnt_term) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Scoreboard bench for axi_wr_burst_ctrl: stimulus queues expected writes and
// B responses, a negedge monitor pops and compares them.
module tb_axi_wr_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_awaddr;
  logic [3:0]  in_awid;
  logic [1:0]  in_awburst;
  logic [2:0]  in_awsize;
  logic [7:0]  in_awlen;
  logic        in_awvalid;
  logic        in_awready;
  logic [63:0] in_wdata;
  logic [7:0]  in_wstrb;
  logic        in_wlast;
  logic        in_wvalid;
  logic        in_wready;
  logic [3:0]  out_bid;
  logic [1:0]  out_bresp;
  logic        out_bvalid;
  logic        out_bready;
  logic [31:0] wr_req_addr;
  logic [63:0] wr_req_data;
  logic [7:0]  wr_req_strb;
  logic        wr_req_valid;
  logic        wr_req_ready;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } wexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] r;
  } bexp_t;

  wexp_t exp_w[$];
  bexp_t exp_b[$];
  int    n_pass  = 0;
  int    n_total = 0;
  bit    tog_mode = 0;
  logic  rdy_fix  = 1'b1;

  axi_wr_burst_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .ID_WIDTH   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_awaddr    (in_awaddr),
    .in_awid      (in_awid),
    .in_awburst   (in_awburst),
    .in_awsize    (in_awsize),
    .in_awlen     (in_awlen),
    .in_awvalid   (in_awvalid),
    .in_awready   (in_awready),
    .in_wdata     (in_wdata),
    .in_wstrb     (in_wstrb),
    .in_wlast     (in_wlast),
    .in_wvalid    (in_wvalid),
    .in_wready    (in_wready),
    .out_bid      (out_bid),
    .out_bresp    (out_bresp),
    .out_bvalid   (out_bvalid),
    .out_bready   (out_bready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_strb  (wr_req_strb),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got no event within bound, required event", name);
  endtask

  // Cache-side ready: fixed level or toggling every cycle.
  initial begin
    wr_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) wr_req_ready = ~wr_req_ready;
      else          wr_req_ready = rdy_fix;
    end
  end

  initial begin : monitor
    wexp_t ew;
    bexp_t eb;
    forever begin
      @(negedge clk);
      if (rst_n && wr_req_valid && wr_req_ready) begin
        if (exp_w.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got write to %h, required none", wr_req_addr);
        end else begin
          ew = exp_w.pop_front();
          chk("wr_addr", wr_req_addr, ew.a);
          chk("wr_data", wr_req_data, ew.d);
          chk("wr_strb", wr_req_strb, ew.s);
        end
      end
      if (rst_n && out_bvalid && out_bready) begin
        if (exp_b.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_b: got bid %h, required no response", out_bid);
        end else begin
          eb = exp_b.pop_front();
          chk("bid", out_bid, eb.id);
          chk("bresp", out_bresp, eb.r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [1:0] bt,
                       input logic [2:0] sz, input logic [7:0] ln);
    bit ok = 0;
    in_awid = id; in_awaddr = a; in_awburst = bt; in_awsize = sz; in_awlen = ln;
    in_awvalid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_awready;
      @(posedge clk);
      #1;
    end
    in_awvalid = 1'b0;
    if (!ok) fail_now("aw_accept");
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic last, input bit drop);
    bit ok = 0;
    in_wdata = d; in_wstrb = s; in_wlast = last; in_wvalid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (drop) begin
        chk("drop_wr_valid", wr_req_valid, 0);
        chk("drop_wready", in_wready, 1);
      end else begin
        chk("wready_mirror", in_wready, wr_req_ready);
        chk("wr_valid", wr_req_valid, 1);
      end
      ok = in_wready;
      @(posedge clk);
      #1;
    end
    in_wvalid = 1'b0;
    in_wlast  = 1'b0;
    if (!ok) fail_now("w_accept");
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk);
      #1;
      ok = (exp_b.size() == 0);
    end
    if (!ok) fail_now("b_response");
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] a, input logic [1:0] bt,
                           input logic [2:0] sz, input logic [7:0] ln, input bit drop,
                           input int last_at, input logic [1:0] eresp,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] ea [4];
    wexp_t e;
    bexp_t b;
    ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
    b.id = id; b.r = eresp;
    exp_b.push_back(b);
    do_aw(id, a, bt, sz, ln);
    for (int i = 0; i <= int'(ln); i++) begin
      e.a = ea[i];
      e.d = {16'hD00D, 12'h0, id, 24'h0, 8'(i)};
      e.s = 8'(8'hFF >> i);
      if (!drop) exp_w.push_back(e);
      send_beat(e.d, e.s, (i == last_at), drop);
    end
  endtask

  initial begin
    wexp_t e;
    bexp_t b;
    rst_n = 1'b0;
    in_awaddr = '0; in_awid = '0; in_awburst = '0; in_awsize = '0; in_awlen = '0;
    in_awvalid = 1'b0; in_wdata = '0; in_wstrb = '0; in_wlast = 1'b0; in_wvalid = 1'b0;
    out_bready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wready", in_wready, 0);
    chk("rst_wr_valid", wr_req_valid, 0);
    chk("rst_bvalid", out_bvalid, 0);
    chk("rst_bid", out_bid, 0);
    chk("rst_bresp", out_bresp, 0);
    chk("rst_wr_addr", wr_req_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awready", in_awready, 1);
    @(posedge clk); #1;

    run_burst(4'h5, 32'h1000, 2'b01, 3'd3, 8'd3, 0, 3, 2'b00,
              32'h1000, 32'h1008, 32'h1010, 32'h1018);
    wait_b();
    run_burst(4'h9, 32'h1018, 2'b10, 3'd3, 8'd3, 0, 3, 2'b00,
              32'h1018, 32'h1000, 32'h1008, 32'h1010);
    wait_b();
    run_burst(4'h6, 32'h3004, 2'b00, 3'd2, 8'd2, 0, 2, 2'b00,
              32'h3004, 32'h3004, 32'h3004, 32'h0);
    wait_b();
    run_burst(4'h4, 32'hFFFF_FFF8, 2'b01, 3'd3, 8'd1, 0, 1, 2'b00,
              32'hFFFF_FFF8, 32'h0000_0000, 32'h0, 32'h0);
    wait_b();

    tog_mode = 1;
    run_burst(4'h3, 32'h2000, 2'b01, 3'd3, 8'd3, 0, 3, 2'b00,
              32'h2000, 32'h2008, 32'h2010, 32'h2018);
    wait_b();
    tog_mode = 0;
    rdy_fix  = 1'b1;

    run_burst(4'h1, 32'h1000, 2'b11, 3'd3, 8'd1, 1, 1, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_b();
    run_burst(4'h2, 32'h1000, 2'b10, 3'd3, 8'd2, 1, 2, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_b();
    run_burst(4'h8, 32'h1000, 2'b01, 3'd4, 8'd0, 1, 0, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_b();
    run_burst(4'h7, 32'h4000, 2'b01, 3'd3, 8'd3, 0, 1, 2'b10,
              32'h4000, 32'h4008, 32'h4010, 32'h4018);
    wait_b();

    // 256-beat INCR burst exercises the full counter range.
    b.id = 4'hB; b.r = 2'b00;
    exp_b.push_back(b);
    do_aw(4'hB, 32'h0001_0000, 2'b01, 3'd3, 8'd255);
    for (int i = 0; i < 256; i++) begin
      e.a = 32'h0001_0000 + 32'(i * 8);
      e.d = {32'hCAFE_0000, 32'(i)};
      e.s = 8'(i) ^ 8'h5A;
      exp_w.push_back(e);
      send_beat(e.d, e.s, (i == 255), 0);
    end
    wait_b();

    out_bready = 1'b0;
    run_burst(4'hC, 32'h5000, 2'b01, 3'd3, 8'd1, 0, 1, 2'b00,
              32'h5000, 32'h5008, 32'h0, 32'h0);
    in_awvalid = 1'b1;
    in_awid = 4'hE; in_awaddr = 32'h9000; in_awburst = 2'b01; in_awlen = 8'd0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_bvalid", out_bvalid, 1);
      chk("hold_bid", out_bid, 4'hC);
      chk("hold_bresp", out_bresp, 2'b00);
      chk("hold_awready", in_awready, 0);
    end
    @(posedge clk); #1;
    in_awvalid = 1'b0;
    out_bready = 1'b1;
    wait_b();

    for (int i = 0; i < 2; i++) begin
      e.a = 32'h6000 + 32'(i * 8);
      e.d = {32'hBEEF_0000, 32'(i)};
      e.s = 8'hFF;
      exp_w.push_back(e);
    end
    do_aw(4'hA, 32'h6000, 2'b01, 3'd3, 8'd3);
    send_beat({32'hBEEF_0000, 32'd0}, 8'hFF, 1'b0, 0);
    send_beat({32'hBEEF_0000, 32'd1}, 8'hFF, 1'b0, 0);
    in_wdata = {32'hBEEF_0000, 32'd2};
    in_wvalid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wready", in_wready, 0);
    chk("midrst_wr_valid", wr_req_valid, 0);
    chk("midrst_bvalid", out_bvalid, 0);
    chk("midrst_bid", out_bid, 0);
    chk("midrst_bresp", out_bresp, 0);
    chk("midrst_wr_addr", wr_req_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_wvalid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("postrst_no_bvalid", out_bvalid, 0);
    end
    chk("postrst_awready", in_awready, 1);
    @(posedge clk); #1;

    run_burst(4'hA, 32'h7000, 2'b01, 3'd3, 8'd1, 0, 1, 2'b00,
              32'h7000, 32'h7008, 32'h0, 32'h0);
    wait_b();

    repeat (3) @(posedge clk);
    chk("w_queue_empty", 64'(exp_w.size()), 0);
    chk("b_queue_empty", 64'(exp_b.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
